// File: rtl/wbmstr_fsm_pv.sv
// rtl/wbmstr_fsm_pv.sv - Wishbone classic master sequencer with ack timeout, saturating error counters, optional TMR state (WBMSTR_FSM_TMR_EN)
module wbmstr_fsm_pv #(
    parameter int                   AddrWidth     = 16,
    parameter int                   DataWidth     = 16,
    parameter int                   TimeoutCycles = 255,
    parameter int                   TimeoutWidth  = 8,
    parameter int                   CntWidth      = 16,
    parameter logic [DataWidth-1:0] ErrData       = {DataWidth{1'b1}},
    parameter int                   StateBitWidth = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           dp0_epty_i,
    output logic                           dp0_rd_o,
    input  logic [AddrWidth+DataWidth:0]   dp0_dt_i,
    input  logic                           dp1_full_i,
    output logic                           dp1_wr_o,
    output logic [AddrWidth+DataWidth-1:0] dp1_dt_o,
    output logic [AddrWidth-1:0]           wb_adr_o,
    output logic [DataWidth-1:0]           wb_dat_o,
    input  logic [DataWidth-1:0]           wb_dat_i,
    output logic                           wb_we_o,
    output logic                           wb_stb_o,
    output logic                           wb_cyc_o,
    input  logic                           wb_ack_i,
    input  logic                           wb_err_i,
    input  logic                           cnt_rst_i,
    output logic [CntWidth-1:0]            wrerr_cnt_o,
    output logic [CntWidth-1:0]            rderr_cnt_o,
    output logic [CntWidth-1:0]            tout_cnt_o,
    output logic [CntWidth-1:0]            seu_cnt_o,
    output logic                           busy_o,
    output logic [StateBitWidth-1:0]       state_o
);

    localparam int                      CmdMsb   = AddrWidth + DataWidth;
    localparam logic [TimeoutWidth-1:0] ToutLast = TimeoutWidth'(TimeoutCycles - 1);

    typedef enum logic [StateBitWidth-1:0] {
        ST_IDLE    = StateBitWidth'(0),
        ST_RDFIFO  = StateBitWidth'(1),
        ST_LATCH   = StateBitWidth'(2),
        ST_WBREQ   = StateBitWidth'(3),
        ST_RSPCHK  = StateBitWidth'(4),
        ST_RSPWR   = StateBitWidth'(5),
        ST_SEU_ERR = StateBitWidth'(6)
    } state_e;

    logic [StateBitWidth-1:0]       state_cur, state_d;
    logic                           seu_mismatch;
    logic                           we_q, we_d;
    logic [AddrWidth-1:0]           adr_q, adr_d;
    logic [DataWidth-1:0]           dat_q, dat_d;
    logic [AddrWidth+DataWidth-1:0] rsp_q, rsp_d;
    logic [TimeoutWidth-1:0]        tmo_q, tmo_d;
    logic [CntWidth-1:0]            wrerr_q, wrerr_d, rderr_q, rderr_d;
    logic [CntWidth-1:0]            tout_q, tout_d, seu_q, seu_d;
    logic                           wr_inc, rd_inc, to_inc, seu_inc;
    logic                           tmo_hit, fail, done;

`ifdef WBMSTR_FSM_TMR_EN
    logic [StateBitWidth-1:0] state_a_q, state_b_q, state_c_q;
    // Bitwise majority of the three replicas; any disagreement is an SEU
    assign state_cur    = (state_a_q & state_b_q) | (state_b_q & state_c_q) | (state_a_q & state_c_q);
    assign seu_mismatch = (state_a_q != state_b_q) || (state_b_q != state_c_q);
`else
    logic [StateBitWidth-1:0] state_q;
    assign state_cur    = state_q;
    assign seu_mismatch = 1'b0;
`endif

    function automatic logic [CntWidth-1:0] cnt_next(input logic [CntWidth-1:0] c,
                                                     input logic inc, input logic clr);
        if (clr) return '0;
        if (inc && (c != '1)) return c + CntWidth'(1);
        return c;
    endfunction

    assign tmo_hit = (tmo_q == ToutLast);
    assign fail    = wb_err_i || (!wb_ack_i && tmo_hit);
    assign done    = wb_err_i || wb_ack_i || tmo_hit;

    // Next-state, datapath latch and counter-increment decode
    always_comb begin
        state_d = state_cur;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rsp_d   = rsp_q;
        tmo_d   = tmo_q;
        wr_inc  = 1'b0;
        rd_inc  = 1'b0;
        to_inc  = 1'b0;
        seu_inc = seu_mismatch;
        case (state_cur)
            ST_IDLE:   if (!dp0_epty_i) state_d = ST_RDFIFO;
            ST_RDFIFO: state_d = ST_LATCH;
            ST_LATCH: begin
                we_d    = dp0_dt_i[CmdMsb];
                adr_d   = dp0_dt_i[CmdMsb-1:DataWidth];
                dat_d   = dp0_dt_i[DataWidth-1:0];
                tmo_d   = '0;
                state_d = ST_WBREQ;
            end
            ST_WBREQ: begin
                tmo_d = tmo_q + TimeoutWidth'(1);
                if (done) begin
                    // ack wins over a simultaneous timeout, err wins over both
                    to_inc = !wb_err_i && !wb_ack_i;
                    if (we_q) begin
                        wr_inc  = fail;
                        state_d = ST_IDLE;
                    end else begin
                        rd_inc  = fail;
                        rsp_d   = {adr_q, fail ? ErrData : wb_dat_i};
                        state_d = ST_RSPCHK;
                    end
                end
            end
            ST_RSPCHK:  if (!dp1_full_i) state_d = ST_RSPWR;
            ST_RSPWR:   state_d = ST_IDLE;
            ST_SEU_ERR: begin
                seu_inc = 1'b1;
                state_d = ST_IDLE;
            end
            default:    state_d = ST_SEU_ERR;
        endcase
        wrerr_d = cnt_next(wrerr_q, wr_inc,  cnt_rst_i);
        rderr_d = cnt_next(rderr_q, rd_inc,  cnt_rst_i);
        tout_d  = cnt_next(tout_q,  to_inc,  cnt_rst_i);
        seu_d   = cnt_next(seu_q,   seu_inc, cnt_rst_i);
    end

    // State, datapath and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
`ifdef WBMSTR_FSM_TMR_EN
            state_a_q <= ST_IDLE;
            state_b_q <= ST_IDLE;
            state_c_q <= ST_IDLE;
`else
            state_q   <= ST_IDLE;
`endif
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            rsp_q   <= '0;
            tmo_q   <= '0;
            wrerr_q <= '0;
            rderr_q <= '0;
            tout_q  <= '0;
            seu_q   <= '0;
        end else begin
`ifdef WBMSTR_FSM_TMR_EN
            state_a_q <= state_d;
            state_b_q <= state_d;
            state_c_q <= state_d;
`else
            state_q   <= state_d;
`endif
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rsp_q   <= rsp_d;
            tmo_q   <= tmo_d;
            wrerr_q <= wrerr_d;
            rderr_q <= rderr_d;
            tout_q  <= tout_d;
            seu_q   <= seu_d;
        end
    end

    assign dp0_rd_o    = (state_cur == ST_RDFIFO);
    assign dp1_wr_o    = (state_cur == ST_RSPWR);
    assign wb_cyc_o    = (state_cur == ST_WBREQ);
    assign wb_stb_o    = (state_cur == ST_WBREQ);
    assign wb_we_o     = (state_cur == ST_WBREQ) && we_q;
    assign busy_o      = (state_cur != ST_IDLE);
    assign state_o     = state_cur;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign dp1_dt_o    = rsp_q;
    assign wrerr_cnt_o = wrerr_q;
    assign rderr_cnt_o = rderr_q;
    assign tout_cnt_o  = tout_q;
    assign seu_cnt_o   = seu_q;

endmodule
